// File: rtl/alu_issue_queue.sv
// alu_issue_queue: collapsing reservation station for the integer ALU.
// Entries are allocated in order at the tail and wake up from one result
// broadcast bus. Each cycle the oldest fully-ready entry is issued through
// registered alu_issue_* outputs.
// Optional feature macro: ALU_IQ_PERF_CNT_EN adds perf_issue_cnt and
// perf_full_stall_cnt.

`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 4
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module alu_issue_queue #(
  parameter int IQ_DEPTH   = 8,
  parameter int PTAG_WIDTH = 6,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          dispatch_en,
  input  logic [`DATA_WIDTH_ALU_OP-1:0] dispatch_op,
  input  logic [`PC_WIDTH-1:0]          dispatch_pc,
  input  logic [`WORD_WIDTH-1:0]        dispatch_imm,
  input  logic [PTAG_WIDTH-1:0]         dispatch_rd_ptag,
  input  logic [PTAG_WIDTH-1:0]         dispatch_rs1_ptag,
  input  logic [PTAG_WIDTH-1:0]         dispatch_rs2_ptag,
  input  logic                          dispatch_rs1_ready,
  input  logic                          dispatch_rs2_ready,
  input  logic [`WORD_WIDTH-1:0]        dispatch_rs1_value,
  input  logic [`WORD_WIDTH-1:0]        dispatch_rs2_value,
  output logic                          iq_full,
  input  logic                          wb_valid,
  input  logic [PTAG_WIDTH-1:0]         wb_ptag,
  input  logic [`WORD_WIDTH-1:0]        wb_value,
  output logic                          alu_issue_en,
  output logic [`DATA_WIDTH_ALU_OP-1:0] alu_issue_queue_op,
  output logic [`PC_WIDTH-1:0]          alu_issue_queue_pc,
  output logic [`WORD_WIDTH-1:0]        alu_issue_queue_imm,
  output logic [`WORD_WIDTH-1:0]        alu_issue_queue_rs1_value,
  output logic [`WORD_WIDTH-1:0]        alu_issue_queue_rs2_value,
`ifdef ALU_IQ_PERF_CNT_EN
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_full_stall_cnt,
`endif
  output logic [PTAG_WIDTH-1:0]         alu_issue_queue_rd_ptag
);

  localparam int IDX_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;

  typedef struct packed {
    logic [`DATA_WIDTH_ALU_OP-1:0] op;
    logic [`PC_WIDTH-1:0]          pc;
    logic [`WORD_WIDTH-1:0]        imm;
    logic [PTAG_WIDTH-1:0]         rd_ptag;
    logic [PTAG_WIDTH-1:0]         rs1_ptag;
    logic                          rs1_ready;
    logic [`WORD_WIDTH-1:0]        rs1_value;
    logic [PTAG_WIDTH-1:0]         rs2_ptag;
    logic                          rs2_ready;
    logic [`WORD_WIDTH-1:0]        rs2_value;
  } entry_t;

  entry_t                ent_q [IQ_DEPTH];
  entry_t                ent_n [IQ_DEPTH];
  entry_t                disp_ent;
  logic [IQ_DEPTH-1:0]   valid_q, valid_n;
  logic [CNT_WIDTH-1:0]  count_q, count_n;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_found;
  logic                  issue_fire;
  logic                  dispatch_fire;

  assign iq_full       = (count_q == CNT_WIDTH'(IQ_DEPTH));
  assign issue_fire    = sel_found & ~flush;
  assign dispatch_fire = dispatch_en & ~iq_full & ~flush;

  // Incoming uop, with same-cycle broadcast bypass for not-ready sources.
  always_comb begin
    disp_ent.op        = dispatch_op;
    disp_ent.pc        = dispatch_pc;
    disp_ent.imm       = dispatch_imm;
    disp_ent.rd_ptag   = dispatch_rd_ptag;
    disp_ent.rs1_ptag  = dispatch_rs1_ptag;
    disp_ent.rs1_ready = dispatch_rs1_ready | (wb_valid && wb_ptag == dispatch_rs1_ptag);
    disp_ent.rs1_value = dispatch_rs1_ready ? dispatch_rs1_value : wb_value;
    disp_ent.rs2_ptag  = dispatch_rs2_ptag;
    disp_ent.rs2_ready = dispatch_rs2_ready | (wb_valid && wb_ptag == dispatch_rs2_ptag);
    disp_ent.rs2_value = dispatch_rs2_ready ? dispatch_rs2_value : wb_value;
  end

  // Select the lowest-index (oldest) valid entry with both sources ready.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && ent_q[i].rs1_ready && ent_q[i].rs2_ready) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Next queue image: collapse over the issued slot, wake up, then append.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments so later steps in
    // this block see the results of earlier ones (collapse -> wakeup -> write).
    for (int i = 0; i < IQ_DEPTH; i++) begin
      ent_n[i]   = ent_q[i];
      valid_n[i] = valid_q[i];
      if (issue_fire && i >= int'(sel_idx)) begin
        ent_n[i]   = ent_q[(i < IQ_DEPTH - 1) ? i + 1 : i];
        valid_n[i] = (i < IQ_DEPTH - 1) ? valid_q[(i < IQ_DEPTH - 1) ? i + 1 : i] : 1'b0;
      end
      if (valid_n[i] && wb_valid) begin
        if (!ent_n[i].rs1_ready && ent_n[i].rs1_ptag == wb_ptag) begin
          ent_n[i].rs1_ready = 1'b1;
          ent_n[i].rs1_value = wb_value;
        end
        if (!ent_n[i].rs2_ready && ent_n[i].rs2_ptag == wb_ptag) begin
          ent_n[i].rs2_ready = 1'b1;
          ent_n[i].rs2_value = wb_value;
        end
      end
      if (dispatch_fire && i == int'(count_q) - (issue_fire ? 1 : 0)) begin
        ent_n[i]   = disp_ent;
        valid_n[i] = 1'b1;
      end
    end
    count_n = count_q + CNT_WIDTH'(dispatch_fire) - CNT_WIDTH'(issue_fire);
    if (flush) begin
      valid_n = '0;
      count_n = '0;
    end
  end

  // Control state and registered issue port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q                   <= '0;
      count_q                   <= '0;
      alu_issue_en              <= 1'b0;
      alu_issue_queue_op        <= '0;
      alu_issue_queue_pc        <= '0;
      alu_issue_queue_imm       <= '0;
      alu_issue_queue_rs1_value <= '0;
      alu_issue_queue_rs2_value <= '0;
      alu_issue_queue_rd_ptag   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values and ordering inside the block is moot.
      valid_q      <= valid_n;
      count_q      <= count_n;
      alu_issue_en <= issue_fire;
      if (issue_fire) begin
        alu_issue_queue_op        <= ent_q[sel_idx].op;
        alu_issue_queue_pc        <= ent_q[sel_idx].pc;
        alu_issue_queue_imm       <= ent_q[sel_idx].imm;
        alu_issue_queue_rs1_value <= ent_q[sel_idx].rs1_value;
        alu_issue_queue_rs2_value <= ent_q[sel_idx].rs2_value;
        alu_issue_queue_rd_ptag   <= ent_q[sel_idx].rd_ptag;
      end
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is qualified by valid_q, so it carries no reset and can
    // map onto plain flops or a register file.
    ent_q <= ent_n;
  end

`ifdef ALU_IQ_PERF_CNT_EN
  // Free-running performance counters; cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issue_cnt      <= '0;
      perf_full_stall_cnt <= '0;
    end else begin
      if (issue_fire)
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (dispatch_en && iq_full)
        perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed and random stimulus against an age-ordered
// queue model of the ALU issue queue. Builds with or without
// ALU_IQ_PERF_CNT_EN.

`ifndef DATA_WIDTH_ALU_OP
`define DATA_WIDTH_ALU_OP 4
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module tb_alu_issue_queue;

  localparam int IQ_DEPTH   = 8;
  localparam int PTAG_WIDTH = 6;
  localparam int CNT_WIDTH  = 4;
  localparam int OW = `DATA_WIDTH_ALU_OP;
  localparam int PW = `PC_WIDTH;
  localparam int WW = `WORD_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  dispatch_en = 1'b0;
  logic [OW-1:0]         dispatch_op = '0;
  logic [PW-1:0]         dispatch_pc = '0;
  logic [WW-1:0]         dispatch_imm = '0;
  logic [PTAG_WIDTH-1:0] dispatch_rd_ptag = '0;
  logic [PTAG_WIDTH-1:0] dispatch_rs1_ptag = '0;
  logic [PTAG_WIDTH-1:0] dispatch_rs2_ptag = '0;
  logic                  dispatch_rs1_ready = 1'b0;
  logic                  dispatch_rs2_ready = 1'b0;
  logic [WW-1:0]         dispatch_rs1_value = '0;
  logic [WW-1:0]         dispatch_rs2_value = '0;
  logic                  iq_full;
  logic                  wb_valid = 1'b0;
  logic [PTAG_WIDTH-1:0] wb_ptag = '0;
  logic [WW-1:0]         wb_value = '0;
  logic                  alu_issue_en;
  logic [OW-1:0]         alu_issue_queue_op;
  logic [PW-1:0]         alu_issue_queue_pc;
  logic [WW-1:0]         alu_issue_queue_imm;
  logic [WW-1:0]         alu_issue_queue_rs1_value;
  logic [WW-1:0]         alu_issue_queue_rs2_value;
  logic [PTAG_WIDTH-1:0] alu_issue_queue_rd_ptag;
`ifdef ALU_IQ_PERF_CNT_EN
  logic [31:0]           perf_issue_cnt;
  logic [31:0]           perf_full_stall_cnt;
`endif

  alu_issue_queue #(
    .IQ_DEPTH(IQ_DEPTH), .PTAG_WIDTH(PTAG_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_en(dispatch_en), .dispatch_op(dispatch_op),
    .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm),
    .dispatch_rd_ptag(dispatch_rd_ptag),
    .dispatch_rs1_ptag(dispatch_rs1_ptag), .dispatch_rs2_ptag(dispatch_rs2_ptag),
    .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
    .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
    .iq_full(iq_full),
    .wb_valid(wb_valid), .wb_ptag(wb_ptag), .wb_value(wb_value),
    .alu_issue_en(alu_issue_en),
    .alu_issue_queue_op(alu_issue_queue_op),
    .alu_issue_queue_pc(alu_issue_queue_pc),
    .alu_issue_queue_imm(alu_issue_queue_imm),
    .alu_issue_queue_rs1_value(alu_issue_queue_rs1_value),
    .alu_issue_queue_rs2_value(alu_issue_queue_rs2_value),
`ifdef ALU_IQ_PERF_CNT_EN
    .perf_issue_cnt(perf_issue_cnt),
    .perf_full_stall_cnt(perf_full_stall_cnt),
`endif
    .alu_issue_queue_rd_ptag(alu_issue_queue_rd_ptag)
  );

  always #5 clk = ~clk;

  // Reference model: a plain age-ordered list of waiting uops.
  typedef struct {
    logic [OW-1:0]         op;
    logic [PW-1:0]         pc;
    logic [WW-1:0]         imm;
    logic [PTAG_WIDTH-1:0] rd;
    logic [PTAG_WIDTH-1:0] t1;
    logic                  r1;
    logic [WW-1:0]         v1;
    logic [PTAG_WIDTH-1:0] t2;
    logic                  r2;
    logic [WW-1:0]         v2;
  } uop_t;

  uop_t        mq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_issue_cnt = 0;
  int unsigned exp_stall_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    dispatch_en = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drive_uop(input logic [OW-1:0] op, input logic [PTAG_WIDTH-1:0] rd,
                           input logic [PTAG_WIDTH-1:0] t1, input logic r1, input logic [WW-1:0] v1,
                           input logic [PTAG_WIDTH-1:0] t2, input logic r2, input logic [WW-1:0] v2);
    dispatch_en        = 1'b1;
    dispatch_op        = op;
    dispatch_pc        = $urandom;
    dispatch_imm       = $urandom;
    dispatch_rd_ptag   = rd;
    dispatch_rs1_ptag  = t1;
    dispatch_rs1_ready = r1;
    dispatch_rs1_value = v1;
    dispatch_rs2_ptag  = t2;
    dispatch_rs2_ready = r2;
    dispatch_rs2_value = v2;
  endtask

  task automatic bcast(input logic [PTAG_WIDTH-1:0] tag, input logic [WW-1:0] val);
    wb_valid = 1'b1;
    wb_ptag  = tag;
    wb_value = val;
  endtask

  // Advance the model over one clock edge with the current inputs, then
  // compare the DUT just after the edge.
  task automatic step();
    int   sel;
    uop_t hit;
    uop_t u;
    logic exp_en;
    logic full_before;
    sel         = -1;
    exp_en      = 1'b0;
    full_before = (mq.size() == IQ_DEPTH);
    for (int k = 0; k < mq.size(); k++)
      if (sel < 0 && mq[k].r1 && mq[k].r2) sel = k;
    if (dispatch_en && full_before) exp_stall_cnt++;
    if (flush) begin
      mq.delete();
    end else begin
      if (sel >= 0) begin
        exp_en = 1'b1;
        hit    = mq[sel];
        mq.delete(sel);
        exp_issue_cnt++;
      end
      if (wb_valid) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (!mq[k].r1 && mq[k].t1 == wb_ptag) begin mq[k].r1 = 1'b1; mq[k].v1 = wb_value; end
          if (!mq[k].r2 && mq[k].t2 == wb_ptag) begin mq[k].r2 = 1'b1; mq[k].v2 = wb_value; end
        end
      end
      if (dispatch_en && !full_before) begin
        u.op  = dispatch_op;
        u.pc  = dispatch_pc;
        u.imm = dispatch_imm;
        u.rd  = dispatch_rd_ptag;
        u.t1  = dispatch_rs1_ptag;
        u.t2  = dispatch_rs2_ptag;
        u.r1  = dispatch_rs1_ready || (wb_valid && wb_ptag == dispatch_rs1_ptag);
        u.r2  = dispatch_rs2_ready || (wb_valid && wb_ptag == dispatch_rs2_ptag);
        u.v1  = dispatch_rs1_ready ? dispatch_rs1_value : wb_value;
        u.v2  = dispatch_rs2_ready ? dispatch_rs2_value : wb_value;
        mq.push_back(u);
      end
    end
    @(posedge clk);
    #1;
    check("issue_en", alu_issue_en, exp_en);
    check("iq_full", iq_full, mq.size() == IQ_DEPTH);
    if (exp_en) begin
      check("issue_op", alu_issue_queue_op, hit.op);
      check("issue_pc", alu_issue_queue_pc, hit.pc);
      check("issue_imm", alu_issue_queue_imm, hit.imm);
      check("issue_rs1", alu_issue_queue_rs1_value, hit.v1);
      check("issue_rs2", alu_issue_queue_rs2_value, hit.v2);
      check("issue_rd", alu_issue_queue_rd_ptag, hit.rd);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef ALU_IQ_PERF_CNT_EN
    check({tag, "_perf_issue"}, perf_issue_cnt, exp_issue_cnt);
    check({tag, "_perf_stall"}, perf_full_stall_cnt, exp_stall_cnt);
`else
    checks = checks + 0;
`endif
  endtask

  initial begin
    // Reset state.
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", alu_issue_en, 1'b0);
    check("rst_full", iq_full, 1'b0);
    check("rst_rd", alu_issue_queue_rd_ptag, '0);
    check("rst_rs1", alu_issue_queue_rs1_value, '0);
    check_perf("rst");
    rst = 1'b0;

    // Single ready ADD issues the following cycle.
    drive_uop(4'd1, 6'd3, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    step();
    idle();
    step();
    check("add_rs1", alu_issue_queue_rs1_value, 32'd5);
    check("add_rs2", alu_issue_queue_rs2_value, 32'd7);
    check("add_rd", alu_issue_queue_rd_ptag, 6'd3);
    step();

    // Younger ready op bypasses an older waiting one; wakeup then issues it.
    drive_uop(4'd2, 6'd11, 6'd9, 1'b0, 32'd0, 6'd1, 1'b1, 32'd1);
    step();
    drive_uop(4'd3, 6'd12, 6'd1, 1'b1, 32'd2, 6'd1, 1'b1, 32'd3);
    step();
    idle();
    step();
    check("bypass_rd", alu_issue_queue_rd_ptag, 6'd12);
    bcast(6'd9, 32'h10);
    step();
    idle();
    step();
    check("wake_rs1", alu_issue_queue_rs1_value, 32'h10);
    check("wake_rd", alu_issue_queue_rd_ptag, 6'd11);

    // Same-cycle broadcast captured at dispatch.
    drive_uop(4'd4, 6'd13, 6'd1, 1'b1, 32'd9, 6'd4, 1'b0, 32'd0);
    bcast(6'd4, 32'hAB);
    step();
    idle();
    step();
    check("capture_rs2", alu_issue_queue_rs2_value, 32'hAB);

    // Fill, drop extra dispatches, then wake from the middle.
    for (int k = 0; k < IQ_DEPTH; k++) begin
      drive_uop(4'd5, PTAG_WIDTH'(k + 20),
                (k == 5) ? 6'd25 : ((k >= 6) ? 6'd30 : PTAG_WIDTH'(40 + k)),
                1'b0, 32'd0, 6'd1, 1'b1, 32'd1);
      step();
    end
    check("fill_full", iq_full, 1'b1);
    drive_uop(4'd6, 6'd60, 6'd1, 1'b1, 32'd1, 6'd1, 1'b1, 32'd1);
    repeat (3) step();
    idle();
    bcast(6'd25, 32'h55);
    step();
    idle();
    step();
    check("mid_rd", alu_issue_queue_rd_ptag, 6'd25);
    check("mid_full_drop", iq_full, 1'b0);
    bcast(6'd30, 32'h66);
    step();
    idle();
    step();
    check("age_rd0", alu_issue_queue_rd_ptag, 6'd26);
    step();
    check("age_rd1", alu_issue_queue_rd_ptag, 6'd27);
    for (int k = 0; k < 5; k++) begin
      bcast(PTAG_WIDTH'(40 + k), $urandom);
      step();
    end
    idle();
    repeat (2) step();
    check_perf("fill");

    // Flush with three ready entries waiting.
    for (int k = 0; k < 3; k++) begin
      drive_uop(4'd7, PTAG_WIDTH'(50 + k), 6'd33, 1'b0, 32'd0, 6'd1, 1'b1, 32'd1);
      step();
    end
    idle();
    bcast(6'd33, 32'h77);
    step();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (4) step();

    // Randomized traffic with occasional flush.
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        drive_uop(OW'($urandom), PTAG_WIDTH'($urandom_range(0, 63)),
                  PTAG_WIDTH'($urandom_range(0, 15)), 1'($urandom), $urandom,
                  PTAG_WIDTH'($urandom_range(0, 15)), 1'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1)
        bcast(PTAG_WIDTH'($urandom_range(0, 15)), $urandom);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    check_perf("random");

    // Asynchronous reset mid-run with entries pending.
    idle();
    drive_uop(4'd8, 6'd9, 6'd20, 1'b0, 32'd0, 6'd1, 1'b1, 32'd1);
    step();
    drive_uop(4'd8, 6'd10, 6'd1, 1'b1, 32'd4, 6'd1, 1'b1, 32'd4);
    step();
    idle();
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    exp_issue_cnt = 0;
    exp_stall_cnt = 0;
    check("arst_en", alu_issue_en, 1'b0);
    check("arst_full", iq_full, 1'b0);
    check("arst_rd", alu_issue_queue_rd_ptag, '0);
    check_perf("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
